// File: rtl/sapra_irq_ctrl.sv
// Vectored interrupt controller: edge-detected channels, enable mask, fixed lowest-index priority, in-service tracking.
// Request visible 2 clocks after a sampled rise; the request holds until irq_ack. Optional preemption via IRQ_NESTING_EN.
module sapra_irq_ctrl #(
  parameter int          NUM_IRQ    = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'h10,
  localparam int         IW         = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               en_wr,
  input  logic [NUM_IRQ-1:0] en_wdata,
  output logic [NUM_IRQ-1:0] irq_en,
  output logic               irq_req,
  output logic [IW-1:0]      irq_num,
  output logic [31:0]        vector,
  input  logic               irq_ack,
  input  logic               irq_eret,
  output logic [NUM_IRQ-1:0] in_service
);

  typedef enum logic [1:0] {IDLE, REQ, ISR} state_t;

  state_t             state, state_nxt;
  logic [NUM_IRQ-1:0] prev_q, pending, pending_nxt, in_service_nxt;
  logic [NUM_IRQ-1:0] rise, cand, ack_mask, isv_acked;
  logic               ack_ok, load_req, win_vld;
  logic [IW-1:0]      win_idx;

  assign rise     = irq_in & ~prev_q;
  assign cand     = pending & irq_en;
  assign ack_ok   = (state == REQ) && irq_ack;
  assign ack_mask = ack_ok ? (NUM_IRQ'(1) << irq_num) : '0;
  assign irq_req  = (state == REQ);

  // A new edge in the ack cycle re-sets the bit the ack clears.
  assign pending_nxt = (pending & ~ack_mask) | (rise & irq_en);

  // Ack lands first; eret then drops the lowest set bit, possibly the one just acked.
  assign isv_acked      = in_service | ack_mask;
  assign in_service_nxt = irq_eret ? (isv_acked & (isv_acked - NUM_IRQ'(1))) : isv_acked;

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_vld = 1'b1;
        win_idx = IW'(i);
      end
    end
  end

`ifdef IRQ_NESTING_EN
  logic [IW-1:0] isv_low;
  always_comb begin
    isv_low = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (in_service_nxt[i]) isv_low = IW'(i);
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    load_req  = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt = REQ;
          load_req  = 1'b1;
        end
      end
      REQ: begin
        if (irq_ack) state_nxt = (in_service_nxt == '0) ? IDLE : ISR;
      end
      ISR: begin
        if (in_service_nxt == '0) begin
          state_nxt = IDLE;
`ifdef IRQ_NESTING_EN
        end else if (win_vld && (win_idx < isv_low)) begin
          state_nxt = REQ;
          load_req  = 1'b1;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prev_q     <= '0;
      pending    <= '0;
      in_service <= '0;
      irq_en     <= '0;
      irq_num    <= '0;
      vector     <= VEC_BASE;
    end else begin
      state      <= state_nxt;
      prev_q     <= irq_in;
      pending    <= pending_nxt;
      in_service <= in_service_nxt;
      if (en_wr) irq_en <= en_wdata;
      // Channel and vector freeze for the whole REQ phase.
      if (load_req) begin
        irq_num <= win_idx;
        vector  <= VEC_BASE + 32'(win_idx) * VEC_STRIDE;
      end
    end
  end

endmodule

// File: tb/tb_sapra_irq_ctrl.sv
// Self-checking bench for sapra_irq_ctrl (NUM_IRQ=4): directed scenarios plus randomized traffic against a rule-level model.
module tb_sapra_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst, en_wr, irq_ack, irq_eret;
  logic [3:0] irq_in, en_wdata, irq_en, in_service;
  logic       irq_req;
  logic [1:0] irq_num;
  logic [31:0] vector;

  int checks = 0;
  int passed = 0;

  // Reference model: sets of bits plus a phase (0 idle, 1 requesting, 2 servicing).
  bit [3:0] m_pend, m_en, m_isv, m_prev;
  int       m_phase, m_ch;

  sapra_irq_ctrl #(.NUM_IRQ(4), .VEC_BASE(32'h100), .VEC_STRIDE(32'h10)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .en_wr(en_wr), .en_wdata(en_wdata),
    .irq_en(irq_en), .irq_req(irq_req), .irq_num(irq_num), .vector(vector),
    .irq_ack(irq_ack), .irq_eret(irq_eret), .in_service(in_service)
  );

  always #5 clk = ~clk;

  function automatic int lowest(bit [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    bit [3:0] pn, isn;
    int win;
    if (rst) begin
      m_pend = 0; m_en = 0; m_isv = 0; m_prev = 0; m_phase = 0; m_ch = 0;
      return;
    end
    win = lowest(m_pend & m_en);
    pn  = m_pend;
    isn = m_isv;
    if (m_phase == 1 && irq_ack) begin
      pn[m_ch]  = 1'b0;
      isn[m_ch] = 1'b1;
    end
    pn = pn | (irq_in & ~m_prev & m_en);
    if (irq_eret && isn != 0) isn[lowest(isn)] = 1'b0;
    if (m_phase == 0) begin
      if (win >= 0) begin m_phase = 1; m_ch = win; end
    end else if (m_phase == 1) begin
      if (irq_ack) m_phase = (isn == 0) ? 0 : 2;
    end else begin
      if (isn == 0) m_phase = 0;
`ifdef IRQ_NESTING_EN
      else if (win >= 0 && win < lowest(isn)) begin m_phase = 1; m_ch = win; end
`endif
    end
    if (en_wr) m_en = en_wdata;
    m_pend = pn;
    m_isv  = isn;
    m_prev = irq_in;
  endtask

  // Advance one clock; the model consumes the same inputs the DUT samples.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1; irq_in = 0; en_wr = 0; en_wdata = 0; irq_ack = 0; irq_eret = 0;
    tick();
    rst = 0;
  endtask

  task automatic set_mask(input logic [3:0] m);
    en_wr = 1; en_wdata = m;
    tick();
    en_wr = 0;
  endtask

  task automatic pulse_ack();
    irq_ack = 1; tick(); irq_ack = 0;
  endtask

  task automatic pulse_eret();
    irq_eret = 1; tick(); irq_eret = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (irq_req !== 1'b0) $display("FAIL reset_req got %b want 0", irq_req); else passed++;
    checks++; if (irq_en !== 4'b0) $display("FAIL reset_en got %b want 0000", irq_en); else passed++;
    checks++; if (vector !== 32'h100) $display("FAIL reset_vector got %h want 00000100", vector); else passed++;
    checks++; if (in_service !== 4'b0 || irq_num !== 2'd0)
      $display("FAIL reset_isv_num got %b/%0d want 0000/0", in_service, irq_num); else passed++;
  endtask

  task automatic test_basic();
    apply_reset();
    set_mask(4'b0010);
    irq_in = 4'b0010;
    tick();
    checks++; if (irq_req !== 1'b0) $display("FAIL basic_early got %b want 0", irq_req); else passed++;
    tick();
    checks++; if (irq_req !== 1'b1 || irq_num !== 2'd1 || vector !== 32'h110)
      $display("FAIL basic_req got %b/%0d/%h want 1/1/00000110", irq_req, irq_num, vector); else passed++;
    irq_in = 0;
    pulse_ack();
    checks++; if (in_service !== 4'b0010 || irq_req !== 1'b0)
      $display("FAIL basic_ack got isv %b req %b want 0010/0", in_service, irq_req); else passed++;
    pulse_eret();
    checks++; if (in_service !== 4'b0 || irq_req !== 1'b0)
      $display("FAIL basic_eret got isv %b req %b want 0000/0", in_service, irq_req); else passed++;
  endtask

  task automatic test_priority();
    apply_reset();
    set_mask(4'b1111);
    irq_in = 4'b1100;
    tick(); tick();
    checks++; if (irq_req !== 1'b1 || irq_num !== 2'd2 || vector !== 32'h120)
      $display("FAIL prio_first got %b/%0d/%h want 1/2/00000120", irq_req, irq_num, vector); else passed++;
    pulse_ack();
    pulse_eret();
    tick();
    checks++; if (irq_req !== 1'b1 || irq_num !== 2'd3 || vector !== 32'h130)
      $display("FAIL prio_second got %b/%0d/%h want 1/3/00000130", irq_req, irq_num, vector); else passed++;
  endtask

  task automatic test_masked_edge();
    int seen;
    apply_reset();
    irq_in = 4'b0001;
    tick();
    set_mask(4'b0001);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (irq_req === 1'b1) seen++;
    end
    checks++; if (seen !== 0) $display("FAIL masked_edge got %0d request cycles want 0", seen); else passed++;
  endtask

  task automatic test_nesting();
    apply_reset();
    set_mask(4'b1111);
    irq_in = 4'b1000;
    tick(); tick();
    pulse_ack();
    irq_in = 4'b1001;
    tick(); tick();
`ifdef IRQ_NESTING_EN
    checks++; if (irq_req !== 1'b1 || irq_num !== 2'd0)
      $display("FAIL nest_preempt got %b/%0d want 1/0", irq_req, irq_num); else passed++;
    pulse_ack();
    checks++; if (in_service !== 4'b1001) $display("FAIL nest_isv got %b want 1001", in_service); else passed++;
    pulse_eret();
    pulse_eret();
    checks++; if (in_service !== 4'b0) $display("FAIL nest_unwind got %b want 0000", in_service); else passed++;
`else
    checks++; if (irq_req !== 1'b0 || in_service !== 4'b1000)
      $display("FAIL nest_blocked got req %b isv %b want 0/1000", irq_req, in_service); else passed++;
    pulse_eret();
    tick();
    checks++; if (irq_req !== 1'b1 || irq_num !== 2'd0)
      $display("FAIL nest_after_eret got %b/%0d want 1/0", irq_req, irq_num); else passed++;
    pulse_ack();
    pulse_eret();
    checks++; if (in_service !== 4'b0) $display("FAIL nest_unwind got %b want 0000", in_service); else passed++;
`endif
    irq_in = 0;
  endtask

  task automatic test_collision_and_reset();
    apply_reset();
    set_mask(4'b0010);
    irq_in = 4'b0010;
    tick(); tick();
    irq_in = 0;
    tick();
    irq_in = 4'b0010;
    pulse_ack();
    checks++; if (irq_req !== 1'b0 || in_service !== 4'b0010)
      $display("FAIL coll_ack got req %b isv %b want 0/0010", irq_req, in_service); else passed++;
    pulse_eret();
    tick();
    checks++; if (irq_req !== 1'b1 || irq_num !== 2'd1)
      $display("FAIL coll_second got %b/%0d want 1/1", irq_req, irq_num); else passed++;
    rst = 1;
    tick();
    rst = 0;
    checks++; if (irq_req !== 1'b0 || irq_en !== 4'b0 || vector !== 32'h100)
      $display("FAIL mid_req_reset got %b/%b/%h want 0/0000/00000100", irq_req, irq_en, vector); else passed++;
  endtask

  task automatic test_random();
    int errs = 0;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(5) == 0) irq_in[b] = ~irq_in[b];
      en_wr    = ($urandom_range(9) == 0);
      en_wdata = 4'($urandom);
      irq_ack  = (m_phase == 1 && $urandom_range(2) == 0) || ($urandom_range(39) == 0);
      irq_eret = ($urandom_range(7) == 0);
      rst      = ($urandom_range(199) == 0);
      tick();
      checks++;
      if (irq_req !== (m_phase == 1) || irq_num !== 2'(m_ch) || vector !== 32'h100 + 32'(m_ch) * 32'h10 ||
          irq_en !== m_en || in_service !== m_isv) begin
        errs++;
        if (errs <= 10)
          $display("FAIL rand_cycle%0d got req %b num %0d vec %h en %b isv %b want %b %0d %h %b %b",
                   c, irq_req, irq_num, vector, irq_en, in_service, (m_phase == 1), m_ch,
                   32'h100 + 32'(m_ch) * 32'h10, m_en, m_isv);
      end else passed++;
    end
    rst = 0; irq_ack = 0; irq_eret = 0; en_wr = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_masked_edge();
    test_nesting();
    test_collision_and_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sapra_irq_ctrl.md
# sapra_irq_ctrl

Parametrised vectored interrupt controller for the SAPRA MIPS core. It replaces the fixed few-line IRQ logic with NUM_IRQ edge-triggered channels, a software-writable enable mask and fixed priority arbitration. It presents one request, with channel number and handler vector, to the PC-select logic, and tracks in-service channels until the handler returns. It sits between external interrupt pins (already synchronised) and the core's IRQ_JAL/VECTOR path.

## Interface

- NUM_IRQ, 4: number of channels, 2..16.
- VEC_BASE, 32'h0000_0100: vector of channel 0.
- VEC_STRIDE, 32'h10: byte spacing between consecutive channel vectors.
- clk  in  1  system clock (CLOCK_50 domain).
- rst  in  1  reset; one clock, synchronous, active-high.
- irq_in  in  NUM_IRQ  interrupt lines, already synchronised to clk, rising-edge triggered.
- en_wr  in  1  mask write strobe.
- en_wdata  in  NUM_IRQ  new enable mask.
- irq_en  out  NUM_IRQ  current enable mask.
- irq_req  out  1  interrupt request to the core.
- irq_num  out  $clog2(NUM_IRQ)  channel being requested.
- vector  out  32  handler address for irq_num.
- irq_ack  in  1  core takes the interrupt (IRQ_JAL), single-cycle pulse.
- irq_eret  in  1  handler return, single-cycle pulse.
- in_service  out  NUM_IRQ  channels currently being serviced.

## Operation

- Reset: irq_en=0, pending=0, in_service=0, irq_req=0, irq_num=0, vector=VEC_BASE, state=IDLE, previous-sample register=0.
- Edge detect: a channel has a rising edge when irq_in[i]=1 and the registered previous sample is 0. On that edge, pending[i] is set only if irq_en[i]=1. Edges on disabled channels are dropped.
- Mask: en_wr loads irq_en. Disabling a channel does not clear its pending bit. The bit is excluded from arbitration until the channel is re-enabled.
- Arbitration: candidates = pending & irq_en. The lowest index has the highest priority. The winner is eligible only if it outranks every in_service bit (see Configuration).
- States:
  - IDLE: no channel in service. An eligible winner moves the block to REQ.
  - REQ: irq_req=1. irq_num and vector are frozen, with no re-arbitration. irq_ack clears pending[irq_num], sets in_service[irq_num] and moves to ISR.
  - ISR: irq_eret clears the lowest-index in_service bit. When in_service becomes 0, go to IDLE. An eligible winner moves to REQ (nesting build only).
- vector = VEC_BASE + irq_num*VEC_STRIDE, computed as a 32-bit value, modulo 2^32.
- Ignored pulses: irq_ack outside REQ is ignored. irq_eret with in_service=0 is ignored.
- Same-channel collision: a new edge on channel i in the same cycle as the ack of i leaves pending[i]=1, so the edge is not lost.
- Masked while requested: if the requested channel is disabled while in REQ, the request stays up until acked.
- Ack and eret together: in the same cycle, the ack is applied first, then the eret clears the lowest set bit. This includes the just-set bit.

## Timing

- irq_in rising at edge k (sampled 1, previous 0): pending set at edge k; irq_req, irq_num and vector registered at edge k+1. Latency is 2 clocks from the sampled rise to a visible request.
- irq_ack at edge k: irq_req=0 from edge k. The next request can appear at edge k+1 at the earliest (nesting build).
- irq_eret at edge k: in_service updated at edge k. A pending lower-priority channel is requested at edge k+1.
- rst overrides everything in its cycle, including mid-REQ and mid-ISR. All state returns to its reset values.

## Configuration

- IRQ_NESTING_EN defined: in ISR, a winner whose index is strictly lower than the lowest in_service bit is eligible, so it preempts. Several in_service bits may be set.
- IRQ_NESTING_EN undefined: no winner is eligible while in_service != 0. At most one in_service bit is set. Requests resume only after irq_eret returns the block to IDLE.

## Test plan

- Basic request: reset, en_wr with 4'b0010, pulse irq_in[1] -> irq_req=1 exactly 2 clocks later, irq_num=1, vector=32'h110. Then irq_ack -> in_service=4'b0010, irq_req=0. Then irq_eret -> in_service=0, state IDLE.
- Priority: mask 4'b1111, edges on irq_in[3] and irq_in[2] in the same cycle -> irq_num=2 first. After ack and eret -> irq_num=3.
- Masked edge: mask 4'b0000, edge on irq_in[0] -> no request ever, even after the mask is set to 4'b0001.
- Nesting: in service on channel 3, edge on channel 0. With IRQ_NESTING_EN -> req with irq_num=0 and in_service=4'b1001 after ack. Without the macro -> no req until irq_eret, then irq_num=0.
- Collision and reset: edge on channel 1 in the ack cycle of channel 1 -> pending stays set, a second request follows the eret. Assert rst during REQ -> irq_req=0, irq_en=0, vector=32'h100 next clock.
